// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encoding
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // funct3 bit positions that classify divide-family operations
  localparam int unsigned OP_DIV_BIT = 2;
  localparam int unsigned OP_REM_BIT = 1;
  localparam int unsigned OP_UNS_BIT = 0;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic mul_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH
  function automatic logic mul_b_signed(input logic [2:0] op);
    return (op == OP_MULH);
  endfunction

  // DIV and REM are signed; DIVU and REMU are not
  function automatic logic div_signed(input logic [2:0] op);
    return !op[OP_UNS_BIT];
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits and shift out one quotient bit.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_c_o,
  output logic [XLEN-1:0] quo_c_o
);

  logic [XLEN:0] part_c;
  logic [XLEN:0] diff_c;

  // Trial subtraction; a borrow (MSB set) means the divisor did not fit
  always_comb begin
    part_c  = {rem_i, quo_i[XLEN-1]};
    diff_c  = part_c - {1'b0, dvs_i};
    rem_c_o = diff_c[XLEN] ? part_c[XLEN-1:0] : diff_c[XLEN-1:0];
    quo_c_o = {quo_i[XLEN-2:0], ~diff_c[XLEN]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshakes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            zero
);

  localparam int unsigned CNT_W    = $clog2(XLEN) + 1;
  localparam int unsigned PW       = 2 * XLEN;
  localparam int unsigned PIPE_D   = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
  localparam int unsigned MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
  localparam int unsigned DIV_LAST = XLEN - 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              rem_sel_q, rem_sel_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic              in_fire_c;
  logic              out_fire_c;
  logic              a_sgn_c, b_sgn_c;
  logic [PW-1:0]     mul_a_c, mul_b_c, prod_c;
  logic [XLEN-1:0]   mul_sel_c;
  logic [XLEN-1:0]   pipe_out_c;
  logic              div_sgn_c, a_neg_c, b_neg_c, b_zero_c, ovf_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  logic [XLEN-1:0]   iter_rem_c, iter_quo_c;
  logic              fin_c;
  logic [XLEN-1:0]   fin_res_c;

  assign in_fire_c  = in_valid & in_ready_q & ~flush;
  assign out_fire_c = out_valid_q & out_ready & ~flush;

  // Full-width product of extended operands, reduced to the requested half
  always_comb begin
    a_sgn_c   = mul_a_signed(op) & A[XLEN-1];
    b_sgn_c   = mul_b_signed(op) & B[XLEN-1];
    mul_a_c   = {{XLEN{a_sgn_c}}, A};
    mul_b_c   = {{XLEN{b_sgn_c}}, B};
    prod_c    = mul_a_c * mul_b_c;
    mul_sel_c = (op == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
  end

  // Operand magnitudes and special-case detection for the divide family
  always_comb begin
    div_sgn_c = div_signed(op);
    a_neg_c   = div_sgn_c & A[XLEN-1];
    b_neg_c   = div_sgn_c & B[XLEN-1];
    a_mag_c   = a_neg_c ? (~A + XLEN'(1)) : A;
    b_mag_c   = b_neg_c ? (~B + XLEN'(1)) : B;
    b_zero_c  = (B == '0);
    ovf_c     = div_sgn_c & (A == SMIN) & (B == '1);
  end

  // Retiming chain behind the multiplier; absent when the product is single-cycle
  if (MUL_CYCLES > 1) begin : g_pipe
    logic [XLEN-1:0] pipe_q [PIPE_D];
    logic            pipe_en_c;

    assign pipe_en_c  = in_fire_c | (state_q == ST_MUL);
    assign pipe_out_c = pipe_q[PIPE_D-1];

    // Shift the product forward while a multiply is in flight
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
      end else if (pipe_en_c) begin
        pipe_q[0] <= mul_sel_c;
        for (int unsigned i = 1; i < PIPE_D; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end else begin : g_nopipe
    assign pipe_out_c = mul_sel_c;
  end

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .rem_i   (rem_q),
    .quo_i   (quo_q),
    .dvs_i   (dvs_q),
    .rem_c_o (iter_rem_c),
    .quo_c_o (iter_quo_c)
  );

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_sel_d   = rem_sel_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    res_d       = res_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    fin_c       = 1'b0;
    fin_res_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_fire_c) begin
          in_ready_d = 1'b0;
          if (op[OP_DIV_BIT]) begin
            rem_sel_d = op[OP_REM_BIT];
            if (b_zero_c) begin
              fin_c     = 1'b1;
              fin_res_c = op[OP_REM_BIT] ? A : '1;
            end else if (ovf_c) begin
              fin_c     = 1'b1;
              fin_res_c = op[OP_REM_BIT] ? '0 : A;
            end else begin
              state_d = ST_DIV;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = a_mag_c;
              dvs_d   = b_mag_c;
              q_neg_d = a_neg_c ^ b_neg_c;
              r_neg_d = a_neg_c;
            end
          end else if (MUL_CYCLES == 1) begin
            fin_c     = 1'b1;
            fin_res_c = mul_sel_c;
          end else begin
            state_d = ST_MUL;
            cnt_d   = '0;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(MUL_LAST)) begin
          fin_c     = 1'b1;
          fin_res_c = pipe_out_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        rem_d = iter_rem_c;
        quo_d = iter_quo_c;
        if (cnt_q == CNT_W'(DIV_LAST)) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX: begin
        fin_c = 1'b1;
        if (rem_sel_q) begin
          fin_res_c = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
        end else begin
          fin_res_c = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
        end
      end
      ST_DONE: begin
        if (out_fire_c) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          zero_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        zero_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase

    if (fin_c) begin
      state_d     = ST_DONE;
      res_d       = fin_res_c;
      zero_d      = (fin_res_c == '0);
      out_valid_d = 1'b1;
    end

    // A pipeline kill overrides everything, including a pending handshake
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      zero_d      = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_sel_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_sel_q   <= rem_sel_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_CYCLES=1).
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int          DIV_LAT = 34;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        zero;

  int unsigned n_chk;
  int unsigned n_err;

  muldiv_unit #(
    .XLEN       (XLEN),
    .MUL_CYCLES (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_in),
    .A         (a_in),
    .B         (b_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count and report
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural result from RV32M rules using 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'(a);
    longint      ub = longint'(b);
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Cycles from accept to out_valid
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 1;
    if (b == 0) return 1;
    if (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return DIV_LAT;
  endfunction

  // Operand mix biased toward boundary values
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, measure latency, check result, hold, then retire it
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string tag);
    logic [31:0] exp;
    int          lat;
    exp = ref_res(o, a, b);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_in    = o;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_in    = 3'($urandom);
    a_in     = $urandom;
    b_in     = $urandom;
    check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(ref_lat(o, a, b)));
    check({tag, ":res"}, res, exp);
    check({tag, ":zero"}, 32'(zero), 32'(exp == 32'd0));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, ":hold_res"}, res, exp);
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":retire_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":retire_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ":retire_zero"}, 32'(zero), 32'd0);
  endtask

  // Run-time guard
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_in     = 3'd0;
    a_in      = '0;
    b_in      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:res", res, 32'd0);
    check("rst:zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
    run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 0, "mulh_7x-3");
    run_op(3'd4, 32'hFFFF_FFEC, 32'd6, 0, "div_-20/6");
    run_op(3'd6, 32'hFFFF_FFEC, 32'd6, 0, "rem_-20/6");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu_5/0");
    run_op(3'd7, 32'd5, 32'd0, 0, "remu_5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_-1xmax");
    run_op(3'd3, 32'd123, 32'd456, 10, "stall10");

    // Flush in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; op_in = 3'd4; a_in = 32'd1000; b_in = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_div:out_valid", 32'(out_valid), 32'd0);
    check("flush_div:in_ready", 32'(in_ready), 32'd1);
    vcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) vcnt++;
    end
    check("flush_div:no_late_valid", 32'(vcnt), 32'd0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 0, "mulhu_after_flush");

    // Flush wins over a same-cycle request
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op_in = 3'd0; a_in = 32'd3; b_in = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req:in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("flush_req:out_valid", 32'(out_valid), 32'd0);

    // Flush while a result is waiting, together with out_ready
    @(negedge clk);
    in_valid = 1'b1; op_in = 3'd0; a_in = 32'd3; b_in = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("flush_done:res", res, 32'd12);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done:out_valid", 32'(out_valid), 32'd0);
    check("flush_done:in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset during a divide
    @(negedge clk);
    in_valid = 1'b1; op_in = 3'd5; a_in = 32'd99; b_in = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst:out_valid", 32'(out_valid), 32'd0);
    check("arst:in_ready", 32'(in_ready), 32'd1);
    check("arst:res", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) vcnt++;
    end
    check("arst:no_late_valid", 32'(vcnt), 32'd0);

    // Randomised operations against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, $urandom_range(0, 3), $sformatf("rnd%0d_op%0d", n, ro));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
